// File: rtl/pcie_ats_pkg.sv
// Shared constants, entry layout and header builders for the ATS invalidate
// responder: CQ field positions, RQ sideband positions and completion format.
package pcie_ats_pkg;

  localparam logic [3:0] REQ_TYPE_MSG     = 4'b1110;
  localparam logic [7:0] INV_REQ_CODE_DEF = 8'h01;
  localparam logic [7:0] INV_CPL_CODE_DEF = 8'h02;
  localparam logic [2:0] ROUTE_BY_ID      = 3'b010;
  localparam logic [2:0] CPL_COUNT_ONE    = 3'b001;

  localparam int HDR_W = 128;

  localparam int REQ_TYPE_LSB = 75;
  localparam int REQID_LSB    = 80;
  localparam int TAG_LSB      = 96;
  localparam int MSG_CODE_LSB = 104;
  localparam int ROUTE_LSB    = 112;
  localparam int DEST_ID_LSB  = 48;
  localparam int ITAG_LSB     = 40;

  localparam int CQ_SOP_LSB      = 80;
  localparam int RQ_IS_SOP_LSB   = 20;
  localparam int RQ_IS_EOP_LSB   = 26;
  localparam int RQ_EOP0_PTR_LSB = 28;
  localparam int RQ_SB_W         = 32;

  localparam int TAG_W   = 8;
  localparam int REQID_W = 16;
  localparam int ENTRY_W = TAG_W + REQID_W;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [REQID_W-1:0] req_id;
  } inv_entry_t;

  // Invalidate-completion header; everything not named here stays zero.
  function automatic logic [HDR_W-1:0] build_cpl_hdr(input inv_entry_t e,
                                                     input logic [7:0] code);
    logic [HDR_W-1:0] h;
    h = '0;
    h[DEST_ID_LSB +: REQID_W] = e.req_id;
    h[ITAG_LSB +: TAG_W]      = e.tag;
    h[2:0]                    = CPL_COUNT_ONE;
    h[REQ_TYPE_LSB +: 4]      = REQ_TYPE_MSG;
    h[TAG_LSB +: TAG_W]       = e.tag;
    h[MSG_CODE_LSB +: 8]      = code;
    h[ROUTE_LSB +: 3]         = ROUTE_BY_ID;
    return h;
  endfunction

  // Single-beat sideband: one SOP, one EOP ending in dword 3 of the header.
  function automatic logic [RQ_SB_W-1:0] build_rq_tuser();
    logic [RQ_SB_W-1:0] u;
    u = '0;
    u[RQ_IS_SOP_LSB +: 2]   = 2'b01;
    u[RQ_IS_EOP_LSB +: 2]   = 2'b01;
    u[RQ_EOP0_PTR_LSB +: 4] = 4'd3;
    return u;
  endfunction

endpackage

// File: rtl/pcie_ats_inv_fifo.sv
// Pending-invalidation queue: power-of-two circular buffer with a
// combinational head, accepting a push while full when a pop frees the slot.
module pcie_ats_inv_fifo
  import pcie_ats_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == FULL_CNT);
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign head_data = mem_r[rptr_r];

  // Qualify requests against occupancy.
  always_comb begin
    do_push_s = push & (~full | pop);
    do_pop_s  = pop & ~empty;
  end

  // Storage array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wptr_r] <= push_data;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (do_push_s) begin
        wptr_r <= wptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rptr_r <= rptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pcie_ats_inv_responder.sv
// Snoops the CQ stream for ATS invalidate requests, passes CQ through untouched,
// and answers each captured request with one invalidate-completion beat on RQ.
module pcie_ats_inv_responder
  import pcie_ats_pkg::*;
#(
  parameter int         AXIS_DATA_WIDTH = 512,
  parameter int         CQ_TUSER_W      = 229,
  parameter int         RQ_TUSER_W      = 183,
  parameter int         DEPTH           = 8,
  parameter logic [7:0] INV_REQ_CODE    = INV_REQ_CODE_DEF,
  parameter logic [7:0] INV_CPL_CODE    = INV_CPL_CODE_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  input  logic [CQ_TUSER_W-1:0]        s_axis_tuser,
  output logic                         s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  output logic [CQ_TUSER_W-1:0]        m_axis_tuser,
  input  logic                         m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]   rq_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] rq_axis_tkeep,
  output logic                         rq_axis_tvalid,
  output logic                         rq_axis_tlast,
  output logic [RQ_TUSER_W-1:0]        rq_axis_tuser,
  input  logic                         rq_axis_tready,
  input  logic                         cfg_enable,
  output logic [$clog2(DEPTH):0]       pend_count,
  output logic [15:0]                  stat_inv_cnt,
  output logic [15:0]                  stat_drop_cnt
);

  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;
  localparam logic [KEEP_W-1:0]     CPL_KEEP  = KEEP_W'(16'hFFFF);
  localparam logic [RQ_TUSER_W-1:0] CPL_TUSER = RQ_TUSER_W'(build_rq_tuser());

  logic                       cap_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       drop_s;
  logic                       full_s;
  logic                       empty_s;
  inv_entry_t                 cap_entry_s;
  logic [ENTRY_W-1:0]         head_raw_s;
  inv_entry_t                 head_s;
  logic [AXIS_DATA_WIDTH-1:0] cpl_tdata_s;

  logic [0:0]                 state_r;
  logic [AXIS_DATA_WIDTH-1:0] rq_tdata_r;
  logic [KEEP_W-1:0]          rq_tkeep_r;
  logic                       rq_tvalid_r;
  logic                       rq_tlast_r;
  logic [RQ_TUSER_W-1:0]      rq_tuser_r;
  logic [15:0]                inv_cnt_r;
  logic [15:0]                drop_cnt_r;

  // The snoop is purely observational so RQ backpressure never reaches CQ.
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tvalid = s_axis_tvalid;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tuser  = s_axis_tuser;
  assign s_axis_tready = m_axis_tready;

  assign rq_axis_tdata  = rq_tdata_r;
  assign rq_axis_tkeep  = rq_tkeep_r;
  assign rq_axis_tvalid = rq_tvalid_r;
  assign rq_axis_tlast  = rq_tlast_r;
  assign rq_axis_tuser  = rq_tuser_r;
  assign stat_inv_cnt   = inv_cnt_r;
  assign stat_drop_cnt  = drop_cnt_r;

  // Recognise an invalidate request on the first beat of an accepted TLP.
  always_comb begin
    cap_entry_s.tag    = s_axis_tdata[TAG_LSB +: TAG_W];
    cap_entry_s.req_id = s_axis_tdata[REQID_LSB +: REQID_W];
    cap_s = s_axis_tvalid & m_axis_tready & cfg_enable
          & (|s_axis_tuser[CQ_SOP_LSB +: 2])
          & (s_axis_tdata[REQ_TYPE_LSB +: 4] == REQ_TYPE_MSG)
          & (s_axis_tdata[MSG_CODE_LSB +: 8] == INV_REQ_CODE);
  end

  // Pop whenever the RQ holding register is free or being accepted this cycle.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      ST_IDLE: pop_s = ~empty_s;
      ST_SEND: pop_s = rq_tvalid_r & rq_axis_tready & ~empty_s;
      default: pop_s = 1'b0;
    endcase
    push_s = cap_s & (~full_s | pop_s);
    drop_s = cap_s & full_s & ~pop_s;
  end

  assign head_s      = inv_entry_t'(head_raw_s);
  assign cpl_tdata_s = AXIS_DATA_WIDTH'(build_cpl_hdr(head_s, INV_CPL_CODE));

  pcie_ats_inv_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (cap_entry_s),
    .pop       (pop_s),
    .head_data (head_raw_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (pend_count)
  );

  // Emitter: IDLE waits for an entry, SEND holds the beat until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rq_tdata_r  <= '0;
      rq_tkeep_r  <= '0;
      rq_tvalid_r <= 1'b0;
      rq_tlast_r  <= 1'b0;
      rq_tuser_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            rq_tdata_r  <= cpl_tdata_s;
            rq_tkeep_r  <= CPL_KEEP;
            rq_tuser_r  <= CPL_TUSER;
            rq_tlast_r  <= 1'b1;
            rq_tvalid_r <= 1'b1;
            state_r     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pop_s) begin
            rq_tdata_r  <= cpl_tdata_s;
            rq_tkeep_r  <= CPL_KEEP;
            rq_tuser_r  <= CPL_TUSER;
            rq_tlast_r  <= 1'b1;
            rq_tvalid_r <= 1'b1;
          end else if (rq_tvalid_r && rq_axis_tready) begin
            rq_tvalid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          rq_tvalid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  // Statistics: captures wrap, drops saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_cnt_r  <= 16'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (push_s) begin
        inv_cnt_r <= inv_cnt_r + 16'd1;
      end
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

endmodule

// File: doc/pcie_ats_inv_responder.md
PCIE_ATS_INV_RESPONDER -- requirements
Module: pcie_ats_inv_responder

Interface
REQ-001 Parameters SHALL be as follows.
- AXIS_DATA_WIDTH, default 512: CQ/RQ tdata width, ≥128.
- CQ_TUSER_W, default 229: CQ tuser width.
- RQ_TUSER_W, default 183: RQ tuser width.
- DEPTH, default 8: pending-invalidation queue entries, power of 2, ≥2.
- INV_REQ_CODE, default 8'h01: accepted message code.
- INV_CPL_CODE, default 8'h02: emitted message code.

REQ-002 Ports SHALL be as follows.
- clk, in, 1: sole clock.
- rst, in, 1: async active-high reset.
- s_axis_tdata / tkeep / tvalid / tlast / tuser, in, W / W/8 / 1 / 1 / CQ_TUSER_W: CQ input.
- s_axis_tready, out, 1: equals m_axis_tready.
- m_axis_tdata / tkeep / tvalid / tlast / tuser, out: combinational copy of s_axis_*.
- m_axis_tready, in, 1: downstream ready.
- rq_axis_tdata / tkeep / tvalid / tlast / tuser, out, W / W/8 / 1 / 1 / RQ_TUSER_W: completion TLPs.
- rq_axis_tready, in, 1: RQ ready.
- cfg_enable, in, 1: capture enable.
- pend_count, out, clog2(DEPTH)+1: queue occupancy.
- stat_inv_cnt, out, 16: invalidations captured, wraps.
- stat_drop_cnt, out, 16: captures lost to full queue, saturates at 16'hFFFF.

Function
REQ-003 Capture SHALL occur on a beat with s_axis_tvalid & s_axis_tready & (s_axis_tuser[81:80]!=0), tdata[78:75]==4'b1110, tdata[111:104]==INV_REQ_CODE, and cfg_enable=1.
REQ-004 A captured entry SHALL be {tag=tdata[103:96], req_id=tdata[95:80]}, written on the capture edge.
REQ-005 Non-SOP beats and non-matching TLPs SHALL NOT affect the queue or counters.
REQ-006 On capture with queue full and no same-cycle pop, the entry SHALL be dropped and stat_drop_cnt incremented; with a same-cycle pop it SHALL be stored.
REQ-007 Push and pop in the same cycle SHALL leave pend_count unchanged.
REQ-008 The emitter FSM SHALL have states IDLE and SEND.
- IDLE: if queue non-empty, pop head, load RQ registers, and go to SEND.
- SEND: hold all rq_axis_* stable while rq_axis_tready=0; on handshake, either pop the next entry and stay in SEND (back-to-back), or clear rq_axis_tvalid and return to IDLE.
REQ-009 Minimum latency SHALL be two cycles: a capture at edge k gives rq_axis_tvalid=1 after edge k+1.
REQ-010 Completion TLP fields SHALL be as follows.
- Single beat, tlast=1, tkeep = low 16 bytes set.
- tdata[63:48]=entry req_id (destination ID); tdata[47:40]=entry tag (ITag echo); tdata[2:0]=3'b001 (completion count); all other bits [63:0] zero.
- tdata[74:64]=0; [78:75]=4'b1110; [103:96]=entry tag; [111:104]=INV_CPL_CODE; [114:112]=3'b010 (route by ID); all other bits to 127 zero; bits above 127 zero.
REQ-011 RQ tuser SHALL be as follows: [21:20]=2'b01, [27:26]=2'b01, [31:28]=4'd3, all other bits zero.
REQ-012 Completions SHALL leave in capture order.
REQ-013 When cfg_enable deasserts, queued and in-flight completions SHALL still drain.
REQ-014 The pass-through path SHALL never be stalled by RQ backpressure or a full queue.

Reset
REQ-015 While rst=1, all state SHALL clear asynchronously.
- FSM=IDLE; queue empty; counters 0.
- rq_axis_tvalid/tlast=0; rq_axis_tdata/tkeep/tuser=0.
REQ-016 Reset mid-SEND SHALL discard the in-flight and queued completions without a partial handshake.

Structure
REQ-017 Package pcie_ats_pkg SHALL hold the request-type, message-code, routing, and tuser bit-position constants and the entry field widths.
REQ-018 The queue SHALL be sub-module pcie_ats_inv_fifo, parametrised by DEPTH and width, exposing push, pop, full, empty, and count.

Verification
REQ-019 A single invalidate (tag 8'h5A, req_id 16'h0100) with rq_axis_tready=1 SHALL produce one RQ beat two cycles later with [103:96]=8'h5A, [63:48]=16'h0100, [111:104]=8'h02.
REQ-020 Three back-to-back invalidates (tags 1, 2, 3) with rq_axis_tready held low for 10 cycles SHALL give pend_count=2, a stable first beat, then tags 1, 2, 3 on consecutive cycles.
REQ-021 DEPTH+3 invalidates with RQ stalled SHALL give stat_drop_cnt=2 and stat_inv_cnt=DEPTH+1.
REQ-022 A non-ATS CQ TLP and a non-SOP beat carrying matching bits SHALL produce no RQ output, counters 0, and a pass-through identical to the input.
REQ-023 rst asserted mid-SEND with 4 entries pending SHALL give rq_axis_tvalid=0 immediately, pend_count=0, and no further output.
REQ-024 A capture while full coinciding with an RQ handshake SHALL be stored, with stat_drop_cnt unchanged.
